// File: rtl/imem_loader.sv
// Debug-side instruction memory loader: packs a valid/ready byte stream into 32-bit words and
// writes them word by word until a HALT word is seen or the memory is full.
module imem_loader #(
   parameter int unsigned DEPTH     = 32,
   parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [31:0] word_count
);

   typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

   state_e      state_q, state_d;
   logic [1:0]  bcnt_q, bcnt_d;
   // Holds the first three bytes of the word being assembled.
   logic [23:0] wbuf_q, wbuf_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] count_q, count_d;
   logic        ovf_q, ovf_d;
   logic [31:0] word_full;
   logic [23:0] wbuf_shift;

   always_comb begin
      if (MSB_FIRST) begin
         wbuf_shift = {wbuf_q[15:0], rx_data};
         word_full  = {wbuf_q, rx_data};
      end else begin
         wbuf_shift = {rx_data, wbuf_q[23:8]};
         word_full  = {rx_data, wbuf_q};
      end
   end

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      wbuf_d  = wbuf_q;
      addr_d  = addr_q;
      data_d  = data_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StRecv;
               addr_d  = 32'd0;
               count_d = 32'd0;
               ovf_d   = 1'b0;
               bcnt_d  = 2'd0;
            end
         end
         StRecv: begin
            if (rx_valid) begin
               wbuf_d = wbuf_shift;
               if (bcnt_q == 2'd3) begin
                  data_d  = word_full;
                  bcnt_d  = 2'd0;
                  state_d = StWrite;
               end else begin
                  bcnt_d = bcnt_q + 2'd1;
               end
            end
         end
         StWrite: begin
            count_d = count_q + 32'd1;
            if (data_q == HALT_WORD) begin
               state_d = StDone;
               ovf_d   = 1'b0;
            end else if (addr_q == 32'(DEPTH - 1)) begin
               state_d = StDone;
               ovf_d   = 1'b1;
            end else begin
               addr_d  = addr_q + 32'd1;
               state_d = StRecv;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         bcnt_q  <= 2'd0;
         wbuf_q  <= 24'd0;
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
         count_q <= 32'd0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         wbuf_q  <= wbuf_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Strobes decode straight from state so they fall with an asynchronous reset.
   assign rx_ready   = (state_q == StRecv);
   assign mem_wr     = (state_q == StWrite);
   assign busy       = (state_q == StRecv) || (state_q == StWrite);
   assign done       = (state_q == StDone);
   assign mem_addr   = addr_q;
   assign mem_data   = data_q;
   assign overflow   = ovf_q;
   assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: three instances (MSB-first, LSB-first, 4-word memory) driven by a
// directed vector table and random programs, checked against a word-level reference model.
module tb_imem_loader;

   localparam int NI   = 3;
   localparam int LOGN = 1024;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NI-1:0]        start, rx_valid, rx_ready, mem_wr, busy, done, overflow;
   logic [NI-1:0][7:0]   rx_data;
   logic [NI-1:0][31:0]  mem_addr, mem_data, word_count;

   int checks   = 0;
   int failures = 0;

   int depth_of [NI] = '{32, 32, 4};
   bit msb_of   [NI] = '{1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   imem_loader #(.DEPTH(32), .HALT_WORD(32'hFFFFFFFF), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .start(start[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
      .rx_ready(rx_ready[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]),
      .mem_data(mem_data[0]), .busy(busy[0]), .done(done[0]), .overflow(overflow[0]),
      .word_count(word_count[0]));

   imem_loader #(.DEPTH(32), .HALT_WORD(32'hFFFFFFFF), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .start(start[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
      .rx_ready(rx_ready[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]),
      .mem_data(mem_data[1]), .busy(busy[1]), .done(done[1]), .overflow(overflow[1]),
      .word_count(word_count[1]));

   imem_loader #(.DEPTH(4), .HALT_WORD(32'hFFFFFFFF), .MSB_FIRST(1'b1)) u_small (
      .clk(clk), .rst(rst), .start(start[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
      .rx_ready(rx_ready[2]), .mem_wr(mem_wr[2]), .mem_addr(mem_addr[2]),
      .mem_data(mem_data[2]), .busy(busy[2]), .done(done[2]), .overflow(overflow[2]),
      .word_count(word_count[2]));

   // Memory-side monitor: logs every write as the memory would see it on negedge.
   logic [31:0]   wr_addr [NI][LOGN];
   logic [31:0]   wr_data [NI][LOGN];
   int            wr_n    [NI] = '{0, 0, 0};
   int            viol    [NI] = '{0, 0, 0};
   logic [NI-1:0] wr_prev = '0;

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (mem_wr[i]) begin
            if (wr_prev[i] || !busy[i] || rx_ready[i]) viol[i]++;
            wr_addr[i][wr_n[i] % LOGN] = mem_addr[i];
            wr_data[i][wr_n[i] % LOGN] = mem_data[i];
            wr_n[i]++;
         end
         wr_prev[i] = mem_wr[i];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_zero(input int i, input string tag);
      check({tag, " rx_ready"}, 32'(rx_ready[i]), 32'd0);
      check({tag, " mem_wr"}, 32'(mem_wr[i]), 32'd0);
      check({tag, " mem_addr"}, mem_addr[i], 32'd0);
      check({tag, " mem_data"}, mem_data[i], 32'd0);
      check({tag, " busy"}, 32'(busy[i]), 32'd0);
      check({tag, " done"}, 32'(done[i]), 32'd0);
      check({tag, " overflow"}, 32'(overflow[i]), 32'd0);
      check({tag, " word_count"}, word_count[i], 32'd0);
   endtask

   // Reference model: pack the byte stream into words, stop at HALT or when memory is full.
   logic [7:0]  stim [$];
   logic [31:0] exp_w [$];
   bit          exp_ovf;

   task automatic model(input int i);
      logic [31:0] word;
      exp_w.delete();
      exp_ovf = 1'b0;
      for (int w = 0; 4 * w + 3 < stim.size(); w++) begin
         if (msb_of[i]) word = {stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]};
         else           word = {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
         exp_w.push_back(word);
         if (word == 32'hFFFFFFFF) break;
         if (exp_w.size() == depth_of[i]) begin
            exp_ovf = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_start(input int i);
      @(posedge clk); #1;
      start[i] = 1'b1;
      @(posedge clk); #1;
      start[i] = 1'b0;
   endtask

   // Feeds stim[] into instance i until done; optional random gaps and start pulses while busy.
   task automatic run_load(input int i, input bit gaps, input bit spam, input string tag,
                           output int base);
      int acc, cyc, extra;
      bit take;
      base = wr_n[i];
      pulse_start(i);
      check({tag, " done cleared"}, 32'(done[i]), 32'd0);
      check({tag, " busy"}, 32'(busy[i]), 32'd1);
      check({tag, " addr restart"}, mem_addr[i], 32'd0);
      acc = 0;
      cyc = 0;
      while (!done[i] && cyc < 3000) begin
         if (acc < stim.size() && (!gaps || $urandom_range(0, 2) != 0)) begin
            rx_valid[i] = 1'b1;
            rx_data[i]  = stim[acc];
         end else begin
            rx_valid[i] = 1'b0;
            rx_data[i]  = 8'($urandom);
         end
         start[i] = spam && ($urandom_range(0, 3) == 0);
         @(negedge clk);
         take = rx_valid[i] && rx_ready[i];
         @(posedge clk); #1;
         if (take) acc++;
         cyc++;
      end
      start[i] = 1'b0;
      check({tag, " finished in budget"}, 32'(done[i]), 32'd1);
      check({tag, " bytes accepted"}, 32'(acc), 32'(4 * exp_w.size()));
      // Bytes offered once done must not be taken.
      extra = 0;
      rx_valid[i] = 1'b1;
      rx_data[i]  = 8'hA5;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (rx_ready[i]) extra++;
      end
      @(posedge clk); #1;
      rx_valid[i] = 1'b0;
      check({tag, " no accept after done"}, 32'(extra), 32'd0);
   endtask

   task automatic verify(input int i, input int base, input string tag);
      check({tag, " write count"}, 32'(wr_n[i] - base), 32'(exp_w.size()));
      for (int k = 0; k < exp_w.size() && k < wr_n[i] - base; k++) begin
         check({tag, " wr addr"}, wr_addr[i][(base + k) % LOGN], 32'(k));
         check({tag, " wr data"}, wr_data[i][(base + k) % LOGN], exp_w[k]);
      end
      check({tag, " done"}, 32'(done[i]), 32'd1);
      check({tag, " busy idle"}, 32'(busy[i]), 32'd0);
      check({tag, " overflow"}, 32'(overflow[i]), 32'(exp_ovf));
      check({tag, " word_count"}, word_count[i], 32'(exp_w.size()));
      check({tag, " last addr"}, mem_addr[i], 32'(exp_w.size() - 1));
      check({tag, " strobe protocol"}, 32'(viol[i]), 32'd0);
   endtask

   // Loads part of a word (or a full word up to its WRITE cycle) then resets asynchronously.
   task automatic reset_mid(input int i, input int nb, input string tag);
      logic [31:0] pat;
      pat = 32'h00221820;
      pulse_start(i);
      for (int k = 0; k < nb; k++) begin
         rx_valid[i] = 1'b1;
         rx_data[i]  = pat[31 - 8 * k -: 8];
         @(posedge clk); #1;
      end
      rx_valid[i] = 1'b0;
      if (nb == 4) begin
         check({tag, " mem_wr next cycle"}, 32'(mem_wr[i]), 32'd1);
         check({tag, " ready low in write"}, 32'(rx_ready[i]), 32'd0);
         check({tag, " assembled word"}, mem_data[i], pat);
      end else begin
         check({tag, " still receiving"}, 32'(rx_ready[i]), 32'd1);
      end
      #2 rst = 1'b1;
      #1 check_zero(i, tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      int           inst;
      int           nb;
      logic [127:0] bytes;
      int           exp_n;
      bit           exp_ovf;
      logic [31:0]  exp_w0;
   } vec_t;

   vec_t        vecs [5];
   logic [31:0] first_img [$];

   initial begin
      int   base;
      int   nw;
      int   i;
      vec_t v;

      rst      = 1'b1;
      start    = '0;
      rx_valid = '0;
      rx_data  = '0;
      #12;
      for (int k = 0; k < NI; k++) check_zero(k, "reset");
      @(negedge clk);
      rst = 1'b0;

      reset_mid(0, 2, "rst in recv");
      reset_mid(0, 4, "rst in write");

      vecs[0] = '{0, 8,  {64'h00221820_FFFFFFFF, 64'h0}, 2, 1'b0, 32'h00221820};
      vecs[1] = '{0, 12, {96'h11223344_55667788_FFFFFFFF, 32'h0}, 3, 1'b0, 32'h11223344};
      vecs[2] = '{1, 8,  {64'h20182200_FFFFFFFF, 64'h0}, 2, 1'b0, 32'h00221820};
      vecs[3] = '{2, 16, 128'h01020304_05060708_090A0B0C_0D0E0F10, 4, 1'b1, 32'h01020304};
      vecs[4] = '{2, 16, 128'h01020304_05060708_090A0B0C_FFFFFFFF, 4, 1'b0, 32'h01020304};

      for (int t = 0; t < 5; t++) begin
         v = vecs[t];
         stim.delete();
         for (int k = 0; k < v.nb; k++) stim.push_back(v.bytes[127 - 8 * k -: 8]);
         model(v.inst);
         run_load(v.inst, 1'b0, 1'b0, $sformatf("vec%0d", t), base);
         check($sformatf("vec%0d table word_count", t), word_count[v.inst], 32'(v.exp_n));
         check($sformatf("vec%0d table overflow", t), 32'(overflow[v.inst]), 32'(v.exp_ovf));
         check($sformatf("vec%0d table first word", t), wr_data[v.inst][base % LOGN], v.exp_w0);
         verify(v.inst, base, $sformatf("vec%0d", t));
      end

      // Random programs: each is loaded gap-free, then again with gaps and stray start pulses.
      for (int r = 0; r < 12; r++) begin
         i  = r % NI;
         nw = (i == 2) ? $urandom_range(1, 7) : $urandom_range(1, 6);
         stim.delete();
         for (int k = 0; k < 4 * nw; k++) stim.push_back(8'($urandom));
         for (int k = 0; k < 4; k++) stim.push_back(8'hFF);
         model(i);
         run_load(i, 1'b0, 1'b0, $sformatf("rnd%0d clean", r), base);
         verify(i, base, $sformatf("rnd%0d clean", r));
         first_img.delete();
         for (int k = 0; k < wr_n[i] - base; k++) first_img.push_back(wr_data[i][(base + k) % LOGN]);
         run_load(i, 1'b1, 1'b1, $sformatf("rnd%0d gaps", r), base);
         verify(i, base, $sformatf("rnd%0d gaps", r));
         for (int k = 0; k < first_img.size() && k < wr_n[i] - base; k++)
            check($sformatf("rnd%0d same image", r), wr_data[i][(base + k) % LOGN], first_img[k]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL global timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
